// File: rtl/fp16_maxpool2x2_stream.sv
// Streaming 2x2 stride-2 fp16 max-pool: one pixel per handshake in raster order,
// a half-row line buffer of horizontal pair maxima, one pooled value per window.
module fp16_maxpool2x2_stream #(
  parameter int IMG_WIDTH  = 24,
  parameter int IMG_HEIGHT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);
  localparam int HALF_W = IMG_WIDTH / 2;
  localparam int CW     = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW     = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int IW     = (HALF_W > 2) ? $clog2(HALF_W) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} row_state_t;

  row_state_t    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [15:0]   pair_q, pair_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          last_q, last_d;
  logic [15:0]   linebuf_q [HALF_W];
  logic          lb_we;
  logic          in_fire;
  logic          out_fire;
  logic [IW-1:0] col_idx;
  logic [15:0]   pair_max;

  // Sign is ignored; exponent-then-mantissa ordering equals comparing the low 15 bits.
  function automatic logic [15:0] fp16_max(input logic [15:0] a, input logic [15:0] b);
    fp16_max = (a[14:0] > b[14:0]) ? a : b;
  endfunction

  assign in_ready   = !rst && (!out_valid_q || out_ready);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign col_idx    = IW'(col_q >> 1);
  assign pair_max   = fp16_max(pair_q, in_data);
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = out_fire && last_q;

  // Next-state: pair/line-buffer updates, result load and raster counters.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    pair_d      = pair_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    last_d      = last_q && !out_fire;
    lb_we       = 1'b0;
    if (in_fire) begin
      case (state_q)
        ROW_EVEN: begin
          if (col_q[0]) begin
            lb_we = 1'b1;
          end else begin
            pair_d = in_data;
          end
        end
        ROW_ODD: begin
          if (col_q[0]) begin
            out_data_d  = fp16_max(linebuf_q[col_idx], pair_max);
            out_valid_d = 1'b1;
            last_d      = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end else begin
            pair_d = in_data;
          end
        end
        default: begin
          pair_d = pair_q;
        end
      endcase
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ROW_EVEN;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end else begin
      lb_we = 1'b0;
    end
  end

  // Control and output registers; reset returns to the frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ROW_EVEN;
      col_q       <= '0;
      row_q       <= '0;
      pair_q      <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pair_q      <= pair_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  // Line buffer needs no reset: every entry is rewritten in an even row before use.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_idx] <= pair_max;
    end
  end
endmodule

// File: tb/tb_fp16_maxpool2x2_stream.sv
// Self-checking bench: a 4x4 instance for directed scenarios and a 24x24
// instance for a random stream, both checked against a window-max reference.
module tb_fp16_maxpool2x2_stream;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data_a = 16'h0000, in_data_b = 16'h0000;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic [15:0] out_data_a, out_data_b;
  logic        out_valid_a, out_valid_b;
  logic        out_ready_a = 1'b1, out_ready_b = 1'b1;
  logic        frame_done_a, frame_done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] frame_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_a[$];
  logic [15:0] got_b[$];
  int acc_cyc_a[$];
  int out_cyc_a[$];
  int done_idx_a[$];
  int done_idx_b[$];
  int stall_a = 0;
  int spur_a = 0;
  int spur_b = 0;
  bit send_done_b = 1'b0;

  fp16_maxpool2x2_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .frame_done(frame_done_a));

  fp16_maxpool2x2_stream #(.IMG_WIDTH(24), .IMG_HEIGHT(24)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .frame_done(frame_done_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are stable at the falling edge and complete at the next rising edge.
  always @(negedge clk) begin
    if (in_valid_a && in_ready_a) acc_cyc_a.push_back(cyc);
    if (in_valid_a && !in_ready_a) stall_a++;
    if (out_valid_a && out_ready_a) begin
      got_a.push_back(out_data_a);
      out_cyc_a.push_back(cyc);
      if (frame_done_a) done_idx_a.push_back(got_a.size());
    end else if (frame_done_a) begin
      spur_a++;
    end
    if (out_valid_b && out_ready_b) begin
      got_b.push_back(out_data_b);
      if (frame_done_b) done_idx_b.push_back(got_b.size());
    end else if (frame_done_b) begin
      spur_b++;
    end
  end

  function automatic int mag(input logic [15:0] v);
    return int'(v & 16'h7FFF);
  endfunction

  // Reference: largest-magnitude pixel of each 2x2 window of the frame at frame_q[base].
  function automatic void pool_ref(input int w, input int h, input int base);
    logic [15:0] best, p;
    for (int wr = 0; wr < h / 2; wr++) begin
      for (int wc = 0; wc < w / 2; wc++) begin
        best = frame_q[base + (2 * wr) * w + 2 * wc];
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            p = frame_q[base + (2 * wr + dr) * w + 2 * wc + dc];
            if (mag(p) > mag(best)) best = p;
          end
        end
        exp_q.push_back(best);
      end
    end
  endfunction

  task automatic clear_mon();
    got_a.delete(); got_b.delete(); acc_cyc_a.delete(); out_cyc_a.delete();
    done_idx_a.delete(); done_idx_b.delete(); exp_q.delete(); frame_q.delete();
    stall_a = 0; spur_a = 0; spur_b = 0;
  endtask

  task automatic load_plan_frame();
    logic [15:0] plan [16] = '{16'h3C00, 16'h4000, 16'h3800, 16'h3C00,
                               16'h3800, 16'h4200, 16'h4000, 16'h3800,
                               16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                               16'h3C00, 16'h3C00, 16'h3C00, 16'h4400};
    for (int i = 0; i < 16; i++) frame_q.push_back(plan[i]);
  endtask

  // Holds in_valid high; the caller drops it after the last pixel.
  task automatic send_a(input logic [15:0] d);
    bit ok = 1'b0;
    in_data_a = d;
    in_valid_a = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready_a) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_a: in_ready=0 after 300 cycles, required 1"); end
  endtask

  task automatic send_b(input logic [15:0] d);
    bit ok = 1'b0;
    in_data_b = d;
    in_valid_b = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL send_b: in_ready=0 after 300 cycles, required 1"); end
  endtask

  task automatic wait_out_a(input int n);
    for (int k = 0; k < 300; k++) begin
      if (got_a.size() >= n) break;
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0 || out_data_a !== 16'h0000 || frame_done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: rdy=%b vld=%b data=%h done=%b, required 0 0 0000 0", in_ready_a, out_valid_a, out_data_a, frame_done_a);
    end
    checks++;
    if (in_ready_b !== 1'b0 || out_valid_b !== 1'b0 || out_data_b !== 16'h0000 || frame_done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: rdy=%b vld=%b data=%h done=%b, required 0 0 0000 0", in_ready_b, out_valid_b, out_data_b, frame_done_b);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_release: in_ready=%b, required 1", in_ready_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] want [4] = '{16'h4200, 16'h4000, 16'h3C00, 16'h4400};
    int br;
    clear_mon();
    load_plan_frame();
    pool_ref(4, 4, 0);
    out_ready_a = 1'b1;
    foreach (frame_q[i]) send_a(frame_q[i]);
    in_valid_a = 1'b0;
    wait_out_a(4);
    checks++;
    if (got_a.size() != 4) begin errors++; $display("FAIL basic_count: got %0d outputs, required 4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== want[i] || got_a[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_data[%0d]: got %h, required %h", i, got_a[i], want[i]);
      end
    end
    checks++;
    if (done_idx_a.size() != 1 || done_idx_a[0] != 4 || spur_a != 0) begin
      errors++; $display("FAIL basic_frame_done: pulses=%0d spurious=%0d, required one with output 4", done_idx_a.size(), spur_a);
    end
    checks++;
    if (acc_cyc_a.size() != 16 || out_cyc_a.size() != 4) begin
      errors++; $display("FAIL basic_latency_records: inputs=%0d outputs=%0d, required 16 and 4", acc_cyc_a.size(), out_cyc_a.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        br = (2 * (w / 2) + 1) * 4 + 2 * (w % 2) + 1;
        checks++;
        if (out_cyc_a[w] != acc_cyc_a[br] + 1) begin
          errors++; $display("FAIL basic_latency[%0d]: output cycle %0d, required %0d", w, out_cyc_a[w], acc_cyc_a[br] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_mon();
    load_plan_frame();
    pool_ref(4, 4, 0);
    out_ready_a = 1'b0;
    fork
      begin
        foreach (frame_q[i]) send_a(frame_q[i]);
        in_valid_a = 1'b0;
      end
      begin
        bit seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (out_valid_a) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_first_valid: out_valid=0 after 100 cycles, required 1"); end
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          checks++;
          if (out_data_a !== exp_q[0] || in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall[%0d]: data=%h rdy=%b vld=%b, required %h 0 1", s, out_data_a, in_ready_a, out_valid_a, exp_q[0]);
          end
        end
        @(posedge clk); #1;
        out_ready_a = 1'b1;
      end
    join
    wait_out_a(4);
    checks++;
    if (got_a.size() != 4 || acc_cyc_a.size() != 16) begin
      errors++; $display("FAIL bp_count: outputs=%0d inputs=%0d, required 4 and 16", got_a.size(), acc_cyc_a.size());
    end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin errors++; $display("FAIL bp_data[%0d]: got %h, required %h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_tie_magnitude();
    logic [15:0] win [4][4];
    logic [15:0] want [3] = '{16'h3C00, 16'h7C00, 16'h0000};
    logic [15:0] px [16];
    win[0] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    win[1] = '{16'h7BFF, 16'h7C00, 16'h0000, 16'h0001};
    win[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int j = 0; j < 4; j++) win[3][j] = 16'($urandom_range(0, 32767));
    clear_mon();
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++)
        px[(2 * (w / 2) + j / 2) * 4 + 2 * (w % 2) + j % 2] = win[w][j];
    for (int i = 0; i < 16; i++) frame_q.push_back(px[i]);
    pool_ref(4, 4, 0);
    foreach (frame_q[i]) send_a(frame_q[i]);
    in_valid_a = 1'b0;
    wait_out_a(4);
    checks++;
    if (got_a.size() != 4) begin errors++; $display("FAIL tie_count: got %0d outputs, required 4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i] || (i < 3 && got_a[i] !== want[i])) begin
        errors++; $display("FAIL tie_data[%0d]: got %h, required %h", i, got_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    for (int i = 0; i < 32; i++) frame_q.push_back(16'($urandom_range(0, 32767)));
    pool_ref(4, 4, 0);
    pool_ref(4, 4, 16);
    out_ready_a = 1'b1;
    foreach (frame_q[i]) send_a(frame_q[i]);
    in_valid_a = 1'b0;
    wait_out_a(8);
    checks++;
    if (got_a.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d outputs, required 8", got_a.size()); end
    for (int i = 0; i < 8 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h, required %h", i, got_a[i], exp_q[i]); end
    end
    checks++;
    if (stall_a != 0) begin errors++; $display("FAIL b2b_in_ready: %0d stalled cycles, required 0", stall_a); end
    checks++;
    if (done_idx_a.size() != 2 || done_idx_a[0] != 4 || done_idx_a[1] != 8 || spur_a != 0) begin
      errors++; $display("FAIL b2b_frame_done: pulses=%0d spurious=%0d, required 2 at outputs 4 and 8", done_idx_a.size(), spur_a);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    for (int i = 0; i < 6; i++) send_a(16'($urandom_range(0, 32767)));
    in_valid_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
      errors++; $display("FAIL midrst_hold: vld=%b rdy=%b, required 0 0", out_valid_a, in_ready_a);
    end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_mon();
    for (int i = 0; i < 16; i++) frame_q.push_back(16'($urandom_range(0, 32767)));
    pool_ref(4, 4, 0);
    foreach (frame_q[i]) send_a(frame_q[i]);
    in_valid_a = 1'b0;
    wait_out_a(4);
    checks++;
    if (got_a.size() != 4) begin errors++; $display("FAIL midrst_count: got %0d outputs, required 4", got_a.size()); end
    for (int i = 0; i < 4 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_data[%0d]: got %h, required %h", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_24();
    clear_mon();
    send_done_b = 1'b0;
    for (int i = 0; i < 576; i++)
      frame_q.push_back(($urandom_range(0, 3) == 0) ? 16'h3C00 : 16'($urandom_range(0, 32767)));
    pool_ref(24, 24, 0);
    fork
      begin
        foreach (frame_q[i]) begin
          if ($urandom_range(0, 3) == 0) begin in_valid_b = 1'b0; @(posedge clk); #1; end
          send_b(frame_q[i]);
        end
        in_valid_b = 1'b0;
        send_done_b = 1'b1;
      end
      begin
        for (int k = 0; k < 20000; k++) begin
          @(posedge clk); #1;
          if (send_done_b && got_b.size() >= 144) break;
          out_ready_b = 1'($urandom_range(0, 1));
        end
        out_ready_b = 1'b1;
      end
    join
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (got_b.size() != 144) begin errors++; $display("FAIL rand24_count: got %0d outputs, required 144", got_b.size()); end
    for (int i = 0; i < 144 && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL rand24_data[%0d]: got %h, required %h", i, got_b[i], exp_q[i]); end
    end
    checks++;
    if (done_idx_b.size() != 1 || done_idx_b[0] != 144 || spur_b != 0) begin
      errors++; $display("FAIL rand24_frame_done: pulses=%0d spurious=%0d, required one with output 144", done_idx_b.size(), spur_b);
    end
  endtask

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    test_reset();
    test_basic();
    test_backpressure();
    test_tie_magnitude();
    test_back_to_back();
    test_reset_midframe();
    test_random_24();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
